// File: rtl/spike_count_decoder.sv
// spike_count_decoder
// Classifies a spiking network's output by rate coding. After a start pulse
// it counts the spikes of each of the N output neurons over a window of
// window_len samples (0 means 256), then scans the counts one neuron per
// cycle to find the winner, and holds the result until it is accepted.
//
// Ports
//   clk            rising-edge clock for all state
//   reset          asynchronous active-high reset
//   enable         network enable; a COUNT cycle is a sample only while high
//   start          single-cycle pulse, starts a window (honoured in IDLE only)
//   window_len     samples per window, 0 encodes 256
//   output_spikes  spike vector from the network's last layer
//   result_ready   consumer accepts the held result
//   busy           high whenever the FSM is not in IDLE
//   result_valid   high exactly while the FSM is in HOLD
//   class_out      index of the winning neuron (lowest index wins ties)
//   max_count      spike count of the winning neuron
//   no_spike       every neuron counted zero spikes
//   tie            another neuron matched the winning count
module spike_count_decoder #(
    parameter int unsigned N     = 2,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned CLS_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [7:0]       window_len,
    input  logic [N-1:0]     output_spikes,
    input  logic             result_ready,
    output logic             busy,
    output logic             result_valid,
    output logic [CLS_W-1:0] class_out,
    output logic [CNT_W-1:0] max_count,
    output logic             no_spike,
    output logic             tie
);

    // Sample counter and latched length are 9 bits so a 256-sample window fits.
    localparam int unsigned LEN_W = 9;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COUNT  = 2'd1;
    localparam logic [1:0] ARGMAX = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] sample_cnt;
    logic [CNT_W-1:0] cnt [N];

    logic [CLS_W-1:0] scan_idx;
    logic [CNT_W-1:0] best_cnt;
    logic [CLS_W-1:0] best_cls;
    logic             best_tie;

    logic             start_window;
    logic             sample_fire;
    logic             last_sample;
    logic             scan_last;
    logic [CNT_W-1:0] cand_cnt;
    logic [CNT_W-1:0] nb_cnt;
    logic [CLS_W-1:0] nb_cls;
    logic             nb_tie;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the argmax step for the neuron under scan.
    always_comb begin
        next_state   = state;
        start_window = 1'b0;
        sample_fire  = 1'b0;
        last_sample  = 1'b0;
        scan_last    = 1'b0;
        cand_cnt     = cnt[scan_idx];
        nb_cnt       = best_cnt;
        nb_cls       = best_cls;
        nb_tie       = best_tie;

        // First scanned neuron seeds the candidate; later ones replace it only
        // on a strictly greater count, so equal counts keep the lower index.
        if (scan_idx == '0) begin
            nb_cnt = cand_cnt;
            nb_cls = '0;
            nb_tie = 1'b0;
        end else if (cand_cnt > best_cnt) begin
            nb_cnt = cand_cnt;
            nb_cls = scan_idx;
            nb_tie = 1'b0;
        end else if (cand_cnt == best_cnt) begin
            nb_tie = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    start_window = 1'b1;
                    next_state   = COUNT;
                end
            end
            COUNT: begin
                if (enable) begin
                    sample_fire = 1'b1;
                    if (sample_cnt + LEN_W'(1) == len_q) begin
                        last_sample = 1'b1;
                        next_state  = ARGMAX;
                    end
                end
            end
            ARGMAX: begin
                if (scan_idx == CLS_W'(N - 1)) begin
                    scan_last  = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                // start in the handshake cycle is deliberately not looked at.
                if (result_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Window length latch and sample counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            sample_cnt <= '0;
        end else if (start_window) begin
            len_q      <= (window_len == 8'd0) ? LEN_W'(256) : LEN_W'(window_len);
            sample_cnt <= '0;
        end else if (sample_fire) begin
            sample_cnt <= sample_cnt + LEN_W'(1);
        end
    end

    // Per-neuron saturating spike counters.
    for (genvar g = 0; g < N; g++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt[g] <= '0;
            end else if (start_window) begin
                cnt[g] <= '0;
            end else if (sample_fire && output_spikes[g] && (cnt[g] != CNT_MAX)) begin
                cnt[g] <= cnt[g] + CNT_W'(1);
            end
        end
    end

    // Argmax scan registers; scan_idx is rewound when the window closes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_idx <= '0;
            best_cnt <= '0;
            best_cls <= '0;
            best_tie <= 1'b0;
        end else if (last_sample) begin
            scan_idx <= '0;
        end else if (state == ARGMAX) begin
            scan_idx <= scan_idx + CLS_W'(1);
            best_cnt <= nb_cnt;
            best_cls <= nb_cls;
            best_tie <= nb_tie;
        end
    end

    // Registered status flags follow the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            busy         <= (next_state != IDLE);
            result_valid <= (next_state == HOLD);
        end
    end

    // Result registers load once on HOLD entry and otherwise keep their value,
    // which keeps them stable through HOLD and visible again in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            class_out <= '0;
            max_count <= '0;
            no_spike  <= 1'b0;
            tie       <= 1'b0;
        end else if (scan_last) begin
            class_out <= nb_cls;
            max_count <= nb_cnt;
            no_spike  <= (nb_cnt == '0);
            tie       <= nb_tie;
        end
    end

endmodule

// File: tb/tb_spike_count_decoder.sv
// Directed bench for spike_count_decoder (N=2, CNT_W=8, CLS_W=1).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_spike_count_decoder;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       start;
    logic [7:0] window_len;
    logic [1:0] output_spikes;
    logic       result_ready;
    logic       busy;
    logic       result_valid;
    logic [0:0] class_out;
    logic [7:0] max_count;
    logic       no_spike;
    logic       tie;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc;

    spike_count_decoder #(.N(2), .CNT_W(8), .CLS_W(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .start        (start),
        .window_len   (window_len),
        .output_spikes(output_spikes),
        .result_ready (result_ready),
        .busy         (busy),
        .result_valid (result_valid),
        .class_out    (class_out),
        .max_count    (max_count),
        .no_spike     (no_spike),
        .tie          (tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle with the given length.
    task automatic start_window(input logic [7:0] len);
        start      = 1'b1;
        window_len = len;
        tick();
        start      = 1'b0;
    endtask

    // Count edges until result_valid, bounded by budget.
    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!result_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("wait_valid_timeout", 32'(result_valid), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [0:0] e_cls, input logic [7:0] e_max,
                                input logic e_tie, input logic e_none);
        chk({tag, "_class"},    32'(class_out), 32'(e_cls));
        chk({tag, "_max"},      32'(max_count), 32'(e_max));
        chk({tag, "_tie"},      32'(tie),       32'(e_tie));
        chk({tag, "_no_spike"}, 32'(no_spike),  32'(e_none));
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        start         = 1'b0;
        window_len    = 8'd0;
        output_spikes = 2'b00;
        result_ready  = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        check_result("rst", 1'b0, 8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // Ten samples of 2'b10 -> class 1, count 10; start mid-window ignored.
        enable        = 1'b1;
        output_spikes = 2'b10;
        start_window(8'd10);
        chk("w10_busy", 32'(busy), 32'd1);
        for (int s = 1; s <= 9; s++) begin
            if (s == 5) begin
                start      = 1'b1;
                window_len = 8'd3;
            end
            tick();
            start = 1'b0;
        end
        chk("w10_valid_s9", 32'(result_valid), 32'd0);
        tick();
        chk("w10_valid_lat1", 32'(result_valid), 32'd0);
        tick();
        chk("w10_valid_lat2", 32'(result_valid), 32'd0);
        tick();
        chk("w10_valid_lat3", 32'(result_valid), 32'd1);
        chk("w10_busy_hold",  32'(busy),         32'd1);
        check_result("w10", 1'b1, 8'd10, 1'b0, 1'b0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("w10_idle_busy",  32'(busy),         32'd0);
        chk("w10_idle_valid", 32'(result_valid), 32'd0);
        check_result("w10_idle", 1'b1, 8'd10, 1'b0, 1'b0);

        // No spikes over four samples -> zero count, tie, no_spike.
        output_spikes = 2'b00;
        start_window(8'd4);
        wait_valid(50, cyc);
        chk("w4_latency", 32'(cyc), 32'd6);
        check_result("w4", 1'b0, 8'd0, 1'b1, 1'b1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // enable toggled every cycle: 20 samples need 39 cycles, result at 41.
        output_spikes = 2'b11;
        enable        = 1'b0;
        start_window(8'd20);
        enable = 1'b1;
        cyc = 0;
        while (!result_valid && cyc < 100) begin
            tick();
            cyc++;
            enable = ~enable;
        end
        chk("w20_valid",   32'(result_valid), 32'd1);
        chk("w20_latency", 32'(cyc),          32'd41);
        check_result("w20", 1'b0, 8'd20, 1'b1, 1'b0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // window_len 0 means 256 samples; neuron 0 saturates at 255.
        enable        = 1'b1;
        output_spikes = 2'b01;
        start_window(8'd0);
        wait_valid(400, cyc);
        chk("w256_latency", 32'(cyc), 32'd258);
        check_result("w256", 1'b0, 8'd255, 1'b0, 1'b0);

        // Held result stays put while not ready; start in HOLD ignored.
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                start      = 1'b1;
                window_len = 8'd5;
            end
            tick();
            start = 1'b0;
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_max",   32'(max_count),    32'd255);
        end
        check_result("hold", 1'b0, 8'd255, 1'b0, 1'b0);
        // Handshake with a simultaneous start: back to IDLE, start dropped.
        result_ready = 1'b1;
        start        = 1'b1;
        window_len   = 8'd5;
        tick();
        result_ready = 1'b0;
        start        = 1'b0;
        chk("hs_busy",  32'(busy),         32'd0);
        chk("hs_valid", 32'(result_valid), 32'd0);
        tick();
        tick();
        chk("hs_start_ignored", 32'(busy), 32'd0);

        // Reset mid-window discards counts; asynchronous effect checked before any edge.
        output_spikes = 2'b11;
        start_window(8'd10);
        tick();
        tick();
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy",  32'(busy),         32'd0);
        chk("arst_valid", 32'(result_valid), 32'd0);
        check_result("arst", 1'b0, 8'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("post_rst_busy",  32'(busy),         32'd0);
        chk("post_rst_valid", 32'(result_valid), 32'd0);

        // Fresh two-sample window after reset.
        output_spikes = 2'b01;
        start_window(8'd2);
        wait_valid(50, cyc);
        chk("w2_latency", 32'(cyc), 32'd4);
        check_result("w2", 1'b0, 8'd2, 1'b0, 1'b0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("w2_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
